// File: rtl/acq_pkg.sv
// acq_pkg
// Shared definitions for the acquisition write controller.
//   state_t          : controller state encoding (IDLE / ARMED / WRITING)
//   PASS_COUNT_WIDTH : width of the completed-pass counter output
package acq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        WRITING = 2'd2
    } state_t;

    localparam int PASS_COUNT_WIDTH = 16;

endpackage

// File: rtl/acq_write_ctrl.sv
// acq_write_ctrl
// Multi-channel BRAM write-enable controller for triggered acquisitions.
// A start request arms the controller; it then waits for the free-running
// BRAM address to wrap to zero and drives per-channel byte write enables for
// last_addr+1 consecutive addresses. Single-shot or continuous (re-arming).
//
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   start_acq    : start request (accepted only in IDLE, without stop_acq)
//   stop_acq     : abort request, returns to IDLE from any state
//   continuous   : re-arm after each pass (latched at accepted start)
//   last_addr    : final address of a pass (latched at accepted start)
//   chan_mask    : per-channel enable (latched at accepted start)
//   address      : free-running BRAM address from the address generator
//   wr_addr      : address delayed one cycle, aligned with wen
//   wen          : write enables, channel c at [c*WEN_WIDTH +: WEN_WIDTH]
//   busy         : controller armed or writing
//   done         : one-cycle pulse on the cycle carrying the final write
//   pass_count   : passes completed since the last accepted start (saturating)
module acq_write_ctrl
    import acq_pkg::*;
#(
    parameter int BRAM_WIDTH = 13,
    parameter int N_CHANNELS = 2,
    parameter int WEN_WIDTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_acq,
    input  logic                             stop_acq,
    input  logic                             continuous,
    input  logic [BRAM_WIDTH-1:0]            last_addr,
    input  logic [N_CHANNELS-1:0]            chan_mask,
    input  logic [BRAM_WIDTH-1:0]            address,
    output logic [BRAM_WIDTH-1:0]            wr_addr,
    output logic [N_CHANNELS*WEN_WIDTH-1:0]  wen,
    output logic                             busy,
    output logic                             done,
    output logic [PASS_COUNT_WIDTH-1:0]      pass_count
);

    state_t                          state;
    logic                            continuous_q;
    logic [BRAM_WIDTH-1:0]           last_addr_q;
    logic [N_CHANNELS-1:0]           chan_mask_q;
    logic [BRAM_WIDTH-1:0]           write_cnt;
    logic [N_CHANNELS*WEN_WIDTH-1:0] wen_mask;
    logic                            write_now;
    logic [BRAM_WIDTH-1:0]           write_idx;
    logic                            final_write;

    // Each enabled channel gets all of its byte enables.
    genvar c;
    generate
        for (c = 0; c < N_CHANNELS; c++) begin : g_wen
            assign wen_mask[c*WEN_WIDTH +: WEN_WIDTH] = {WEN_WIDTH{chan_mask_q[c]}};
        end
    endgenerate

    // Decide whether the address sampled this edge is written, and its index
    // within the pass. Because wen is registered alongside wr_addr (the
    // delayed address), the write for address 0 is launched on the same edge
    // that sees the wrap in ARMED, so write_idx is 0 there; in WRITING it is
    // the running counter. An abort suppresses the write immediately.
    always_comb begin
        write_now = 1'b0;
        write_idx = write_cnt;
        if (!stop_acq) begin
            case (state)
                ARMED: begin
                    if (address == '0) begin
                        write_now = 1'b1;
                        write_idx = '0;
                    end
                end
                WRITING: begin
                    write_now = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign final_write = write_now && (write_idx == last_addr_q);

    // Main controller. busy stays high through the cycle carrying the final
    // write and drops on the following one when the pass ends in IDLE.
    // The counter never needs to wrap: the pass ends at last_addr, which is at
    // most all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            continuous_q <= 1'b0;
            last_addr_q  <= '0;
            chan_mask_q  <= '0;
            write_cnt    <= '0;
            wr_addr      <= '0;
            wen          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_count   <= '0;
        end else begin
            wr_addr <= address;
            wen     <= write_now ? wen_mask : '0;
            done    <= 1'b0;

            if (stop_acq) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                        if (start_acq) begin
                            continuous_q <= continuous;
                            last_addr_q  <= last_addr;
                            chan_mask_q  <= chan_mask;
                            pass_count   <= '0;
                            write_cnt    <= '0;
                            state        <= ARMED;
                            busy         <= 1'b1;
                        end
                    end
                    ARMED, WRITING: begin
                        busy <= 1'b1;
                        if (write_now) begin
                            write_cnt <= write_idx + 1'b1;
                            if (final_write) begin
                                done <= 1'b1;
                                if (pass_count != '1) begin
                                    pass_count <= pass_count + 1'b1;
                                end
                                write_cnt <= '0;
                                state     <= continuous_q ? ARMED : IDLE;
                            end else begin
                                state <= WRITING;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_write_ctrl.sv
// tb_acq_write_ctrl
// Self-checking bench for acq_write_ctrl with BRAM_WIDTH=4, N_CHANNELS=2,
// WEN_WIDTH=4. Expected write beats are queued when a scenario is started;
// a monitor pops and compares one entry for every cycle on which the DUT
// shows wen or done. Inputs (including the address generator) change on the
// falling edge; outputs are read mid-cycle.
module tb_acq_write_ctrl;

    localparam int BW = 4;
    localparam int NC = 2;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_acq;
    logic          stop_acq;
    logic          continuous;
    logic [BW-1:0] last_addr;
    logic [NC-1:0] chan_mask;
    logic [BW-1:0] address;
    logic [BW-1:0] wr_addr;
    logic [NC*WW-1:0] wen;
    logic          busy;
    logic          done;
    logic [15:0]   pass_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [BW-1:0]    addr;
        logic [NC*WW-1:0] wen;
        logic             done;
        logic [15:0]      pc;
    } beat_t;

    beat_t sb[$];

    acq_write_ctrl #(
        .BRAM_WIDTH(BW),
        .N_CHANNELS(NC),
        .WEN_WIDTH (WW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_acq (start_acq),
        .stop_acq  (stop_acq),
        .continuous(continuous),
        .last_addr (last_addr),
        .chan_mask (chan_mask),
        .address   (address),
        .wr_addr   (wr_addr),
        .wen       (wen),
        .busy      (busy),
        .done      (done),
        .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    // Advance one cycle; the address generator increments by one per cycle.
    task automatic tick();
        @(negedge clk);
        address = address + 4'd1;
    endtask

    function automatic logic [NC*WW-1:0] expand(input logic [NC-1:0] m);
        expand = {{WW{m[1]}}, {WW{m[0]}}};
    endfunction

    // Queue the expected beats of one pass (or the first n_writes of it).
    task automatic push_pass(input logic [BW-1:0] last, input logic [NC-1:0] m,
                             input int n_writes, input logic [15:0] pc_before);
        beat_t b;
        for (int i = 0; i < n_writes; i++) begin
            b.addr = i[BW-1:0];
            b.wen  = expand(m);
            b.done = (i == int'(last));
            b.pc   = (i == int'(last)) ? pc_before + 16'd1 : pc_before;
            sb.push_back(b);
        end
    endtask

    // Accepted start; inputs are scrambled afterwards so a design that fails
    // to latch its configuration produces wrong beats.
    task automatic do_start(input logic cont, input logic [BW-1:0] last,
                            input logic [NC-1:0] m);
        continuous = cont;
        last_addr  = last;
        chan_mask  = m;
        start_acq  = 1'b1;
        tick();
        start_acq  = 1'b0;
        continuous = ~cont;
        last_addr  = ~last;
        chan_mask  = ~m;
    endtask

    // Wait (bounded) for the scoreboard to hold at most 'left' entries.
    task automatic wait_queue(input string name, input int left, input int budget);
        int n = 0;
        while (sb.size() > left && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() > left) begin
            errors++;
            $display("[TB] FAIL %s_timeout: %0d beats outstanding, expected %0d", name, sb.size(), left);
            sb.delete();
        end
    endtask

    // Monitor: every cycle with wen or done must match the next queued beat.
    initial begin
        beat_t e;
        forever begin
            @(posedge clk);
            #1;
            if (wen !== '0 || done !== 1'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: wr_addr=%0d wen=%h done=%b pass_count=%0d, expected no write",
                             wr_addr, wen, done, pass_count);
                end else begin
                    e = sb.pop_front();
                    if (wr_addr !== e.addr || wen !== e.wen || done !== e.done || pass_count !== e.pc) begin
                        errors++;
                        $display("[TB] FAIL write_beat: got wr_addr=%0d wen=%h done=%b pass_count=%0d, expected wr_addr=%0d wen=%h done=%b pass_count=%0d",
                                 wr_addr, wen, done, pass_count, e.addr, e.wen, e.done, e.pc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1; start_acq = 1'b0; stop_acq = 1'b0; continuous = 1'b0;
        last_addr = '0; chan_mask = '0; address = '0;
        repeat (3) tick();
        checks++; if (wen !== '0)        begin errors++; $display("[TB] FAIL reset_wen: got %h, expected 00", wen); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
        checks++; if (pass_count !== '0) begin errors++; $display("[TB] FAIL reset_pass_count: got %0d, expected 0", pass_count); end
        checks++; if (wr_addr !== '0)    begin errors++; $display("[TB] FAIL reset_wr_addr: got %0d, expected 0", wr_addr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_shot();
        int n = 0;
        while (address != 4'd5 && n < 32) begin tick(); n++; end
        push_pass(4'd15, 2'b11, 16, 16'd0);
        do_start(1'b0, 4'd15, 2'b11);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_rise: got %b, expected 1", busy); end
        checks++; if (wen !== '0)    begin errors++; $display("[TB] FAIL single_no_early_wen: got %h, expected 00", wen); end
        wait_queue("single", 0, 40);
        tick();
        checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL single_busy_fall: got %b, expected 0", busy); end
        checks++; if (pass_count !== 16'd1) begin errors++; $display("[TB] FAIL single_pass_count: got %0d, expected 1", pass_count); end
        checks++; if (done !== 1'b0)        begin errors++; $display("[TB] FAIL single_done_pulse: got %b, expected 0", done); end
        repeat (20) tick();
    endtask

    task automatic test_continuous();
        push_pass(4'd3, 2'b10, 4, 16'd0);
        push_pass(4'd3, 2'b10, 4, 16'd1);
        push_pass(4'd3, 2'b10, 4, 16'd2);
        do_start(1'b1, 4'd3, 2'b10);
        wait_queue("continuous", 0, 100);
        checks++; if (busy !== 1'b1)        begin errors++; $display("[TB] FAIL cont_busy: got %b, expected 1", busy); end
        checks++; if (pass_count !== 16'd3) begin errors++; $display("[TB] FAIL cont_pass_count: got %0d, expected 3", pass_count); end
        stop_acq = 1'b1;
        tick();
        stop_acq = 1'b0;
        checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL cont_stop_busy: got %b, expected 0", busy); end
        checks++; if (pass_count !== 16'd3) begin errors++; $display("[TB] FAIL cont_stop_pass_count: got %0d, expected 3", pass_count); end
        repeat (20) tick();
    endtask

    task automatic test_stop_mid_pass();
        push_pass(4'd7, 2'b11, 8, 16'd0);
        push_pass(4'd7, 2'b11, 3, 16'd1);
        do_start(1'b1, 4'd7, 2'b11);
        wait_queue("stop", 0, 60);
        stop_acq = 1'b1;
        tick();
        stop_acq = 1'b0;
        checks++; if (wen !== '0)           begin errors++; $display("[TB] FAIL stop_wen: got %h, expected 00", wen); end
        checks++; if (done !== 1'b0)        begin errors++; $display("[TB] FAIL stop_done: got %b, expected 0", done); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL stop_busy: got %b, expected 0", busy); end
        checks++; if (pass_count !== 16'd1) begin errors++; $display("[TB] FAIL stop_pass_count: got %0d, expected 1", pass_count); end
        repeat (20) tick();
        checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL stop_stays_idle: got %b, expected 0", busy); end
    endtask

    task automatic test_start_stop_together();
        continuous = 1'b1; last_addr = 4'd2; chan_mask = 2'b11;
        start_acq = 1'b1; stop_acq = 1'b1;
        tick();
        start_acq = 1'b0; stop_acq = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL startstop_busy: got %b, expected 0", busy); end
        repeat (20) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL startstop_idle: got %b, expected 0", busy); end
    endtask

    task automatic test_ignore_restart();
        push_pass(4'd3, 2'b01, 4, 16'd0);
        do_start(1'b0, 4'd3, 2'b01);
        wait_queue("restart_first", 3, 40);
        continuous = 1'b1; last_addr = 4'd15; chan_mask = 2'b11; start_acq = 1'b1;
        tick();
        start_acq = 1'b0;
        wait_queue("restart", 0, 20);
        tick();
        checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL restart_busy: got %b, expected 0", busy); end
        checks++; if (pass_count !== 16'd1) begin errors++; $display("[TB] FAIL restart_pass_count: got %0d, expected 1", pass_count); end
        repeat (20) tick();
    endtask

    task automatic test_last_zero();
        push_pass(4'd0, 2'b11, 1, 16'd0);
        do_start(1'b0, 4'd0, 2'b11);
        wait_queue("last_zero", 0, 40);
        tick();
        checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL lastzero_busy: got %b, expected 0", busy); end
        checks++; if (pass_count !== 16'd1) begin errors++; $display("[TB] FAIL lastzero_pass_count: got %0d, expected 1", pass_count); end
        checks++; if (wen !== '0)           begin errors++; $display("[TB] FAIL lastzero_single_beat: got %h, expected 00", wen); end
        repeat (20) tick();
    endtask

    task automatic test_reset_mid_pass();
        push_pass(4'd15, 2'b11, 16, 16'd0);
        push_pass(4'd15, 2'b11, 4, 16'd1);
        do_start(1'b1, 4'd15, 2'b11);
        wait_queue("reset_mid", 0, 60);
        checks++; if (pass_count !== 16'd1) begin errors++; $display("[TB] FAIL rstmid_pre_count: got %0d, expected 1", pass_count); end
        rst = 1'b1;
        tick();
        checks++; if (wen !== '0)        begin errors++; $display("[TB] FAIL rstmid_wen: got %h, expected 00", wen); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL rstmid_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("[TB] FAIL rstmid_done: got %b, expected 0", done); end
        checks++; if (pass_count !== '0) begin errors++; $display("[TB] FAIL rstmid_pass_count: got %0d, expected 0", pass_count); end
        checks++; if (wr_addr !== '0)    begin errors++; $display("[TB] FAIL rstmid_wr_addr: got %0d, expected 0", wr_addr); end
        rst = 1'b0;
        tick();
        test_single_shot();
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_continuous();
        test_stop_mid_pass();
        test_start_stop_together();
        test_ignore_restart();
        test_last_zero();
        test_reset_mid_pass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
